// File: rtl/prim_shadow_pkg.sv
// Shared types for the shadowed register controller: phase FSM encoding and
// bit positions of the error flags reported to the alert logic.
package prim_shadow_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STAGED = 1'b1
  } state_e;

  localparam int unsigned ErrUpdate  = 0;
  localparam int unsigned ErrStorage = 1;
  localparam int unsigned NumErr     = 2;

endpackage

// File: rtl/prim_shadow_reg_ctrl_if.sv
// Software write / status bundle of the shadowed register controller.
interface prim_shadow_reg_ctrl_if #(
  parameter int unsigned Width = 8
);

  logic             we_i;
  logic [Width-1:0] wd_i;
  logic             phase_clr_i;
  logic [Width-1:0] err_inject_i;
  logic [Width-1:0] q_o;
  logic             qe_o;
  logic             staged_o;
  logic             update_err_o;
  logic             storage_err_o;

  modport master (
    output we_i, wd_i, phase_clr_i, err_inject_i,
    input  q_o, qe_o, staged_o, update_err_o, storage_err_o
  );

  modport slave (
    input  we_i, wd_i, phase_clr_i, err_inject_i,
    output q_o, qe_o, staged_o, update_err_o, storage_err_o
  );

endinterface

// File: rtl/prim_flop.sv
// Generic asynchronous-reset flop primitive used for all register storage.
module prim_flop #(
  parameter int unsigned            Width      = 1,
  parameter logic [Width-1:0]       ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q <= ResetValue;
    else         q <= d;
  end

endmodule

// File: rtl/prim_shadow_stage.sv
// First-phase staging register plus the two-phase FSM; flags whether the
// second write of a pair matches the staged value.
module prim_shadow_stage
  import prim_shadow_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we,
  input  logic [Width-1:0] wd,
  input  logic             phase_clr,
  output logic             commit,
  output logic             mismatch,
  output logic             staged
);

  state_e           state;
  logic [Width-1:0] staging;
  logic [Width-1:0] staging_d;
  logic             wr;

  // A phase clear swallows any write presented in the same cycle.
  assign wr        = we & ~phase_clr;
  assign staging_d = (wr && state == IDLE) ? wd : staging;

  prim_flop #(
    .Width     (Width),
    .ResetValue({Width{1'b0}})
  ) u_staging (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d     (staging_d),
    .q     (staging)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else if (phase_clr) begin
      state <= IDLE;
    end else if (we) begin
      state <= (state == IDLE) ? STAGED : IDLE;
    end
  end

  assign commit   = wr && (state == STAGED) && (wd == staging);
  assign mismatch = wr && (state == STAGED) && (wd != staging);
  assign staged   = (state == STAGED);

endmodule

// File: rtl/prim_shadow_reg_ctrl.sv
// Shadowed configuration register: two matching writes commit a value, which
// is stored alongside an inverted shadow copy that is checked every cycle.
module prim_shadow_reg_ctrl
  import prim_shadow_pkg::*;
#(
  parameter int unsigned      Width      = 8,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  prim_shadow_reg_ctrl_if.slave  bus
);

  logic             commit;
  logic             mismatch;
  logic             staged;
  logic [Width-1:0] committed;
  logic [Width-1:0] committed_d;
  logic [Width-1:0] shadow;
  logic [Width-1:0] shadow_d;
  logic             integrity_fail;
  logic             qe;
  logic [NumErr-1:0] err;

  prim_shadow_stage #(
    .Width(Width)
  ) u_stage (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .we       (bus.we_i),
    .wd       (bus.wd_i),
    .phase_clr(bus.phase_clr_i),
    .commit   (commit),
    .mismatch (mismatch),
    .staged   (staged)
  );

  // Injected faults land on top of whatever the shadow would have become.
  assign committed_d = commit ? bus.wd_i : committed;
  assign shadow_d    = (commit ? ~bus.wd_i : shadow) ^ bus.err_inject_i;

  prim_flop #(
    .Width     (Width),
    .ResetValue(ResetValue)
  ) u_committed (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d     (committed_d),
    .q     (committed)
  );

  prim_flop #(
    .Width     (Width),
    .ResetValue(~ResetValue)
  ) u_shadow (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d     (shadow_d),
    .q     (shadow)
  );

  assign integrity_fail = (committed != ~shadow);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      qe  <= 1'b0;
      err <= '0;
    end else begin
      qe              <= commit;
      err[ErrUpdate]  <= mismatch;
      err[ErrStorage] <= err[ErrStorage] | integrity_fail;
    end
  end

  assign bus.q_o           = committed;
  assign bus.qe_o          = qe;
  assign bus.staged_o      = staged;
  assign bus.update_err_o  = err[ErrUpdate];
  assign bus.storage_err_o = err[ErrStorage];

endmodule

// File: tb/tb_prim_shadow_reg_ctrl.sv
// Scoreboard bench: the driver predicts each cycle's outputs from a behavioural
// model and queues them; a monitor compares them against the DUT on negedges.
module tb_prim_shadow_reg_ctrl;

  typedef struct {
    int         due;
    logic [7:0] q;
    logic       qe;
    logic       staged;
    logic       ue;
    logic       serr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  // Behavioural model state
  logic [7:0] m_q, m_shadow, m_stage;
  logic       m_pend, m_qe, m_ue, m_serr;

  prim_shadow_reg_ctrl_if #(.Width(8)) bus ();

  prim_shadow_reg_ctrl #(
    .Width     (8),
    .ResetValue(8'h5A)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_exp(input int due);
    exp_t e;
    e.due = due; e.q = m_q; e.qe = m_qe; e.staged = m_pend; e.ue = m_ue; e.serr = m_serr;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    m_q = 8'h5A; m_shadow = 8'hA5; m_stage = 8'h00;
    m_pend = 1'b0; m_qe = 1'b0; m_ue = 1'b0; m_serr = 1'b0;
  endtask

  task automatic drive_idle();
    bus.we_i = 1'b0; bus.wd_i = 8'h00; bus.phase_clr_i = 1'b0; bus.err_inject_i = 8'h00;
  endtask

  // One clock of stimulus; the model's view of the resulting outputs is due next cycle.
  task automatic step(input bit we, input logic [7:0] wd, input bit clr, input logic [7:0] inj);
    bit mism;
    @(posedge clk); #1;
    bus.we_i = we; bus.wd_i = wd; bus.phase_clr_i = clr; bus.err_inject_i = inj;
    mism = (m_q != ~m_shadow);
    m_qe = 1'b0; m_ue = 1'b0;
    if (clr) m_pend = 1'b0;
    else if (we) begin
      if (!m_pend) begin
        m_pend = 1'b1; m_stage = wd;
      end else begin
        m_pend = 1'b0;
        if (wd == m_stage) begin
          m_q = wd; m_shadow = ~wd; m_qe = 1'b1;
        end else m_ue = 1'b1;
      end
    end
    m_shadow = m_shadow ^ inj;
    m_serr = m_serr | mism;
    push_exp(cyc + 1);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  // Asynchronous reset asserted mid-cycle: outputs return to reset values at once.
  task automatic do_reset(input int hold);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive_idle();
    model_reset();
    sb.delete();
    push_exp(cyc);
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
      push_exp(cyc);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_exp(cyc);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.due != cyc) begin
        checks++; failures++;
        $display("FAIL sb_stale cycle=%0d actual_due=%0d expected_due=%0d", cyc, e.due, cyc);
      end else begin
        check("q", bus.q_o, e.q);
        check("qe", bus.qe_o, e.qe);
        check("staged", bus.staged_o, e.staged);
        check("update_err", bus.update_err_o, e.ue);
        check("storage_err", bus.storage_err_o, e.serr);
        check("qe_ue_excl", bus.qe_o & bus.update_err_o, 1'b0);
      end
    end
  end

  initial begin
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    do_reset(2);

    // 1: reset state
    idle(); @(negedge clk);
    check("t1_q", bus.q_o, 8'h5A);
    check("t1_staged", bus.staged_o, 1'b0);
    check("t1_storage_err", bus.storage_err_o, 1'b0);

    // 2: matching pair commits
    step(1'b1, 8'h3C, 1'b0, 8'h00); idle(); @(negedge clk);
    check("t2_staged_first", bus.staged_o, 1'b1);
    check("t2_q_held", bus.q_o, 8'h5A);
    step(1'b1, 8'h3C, 1'b0, 8'h00); idle(); @(negedge clk);
    check("t2_q", bus.q_o, 8'h3C);
    check("t2_qe", bus.qe_o, 1'b1);
    check("t2_staged_after", bus.staged_o, 1'b0);
    idle(); @(negedge clk);
    check("t2_qe_single", bus.qe_o, 1'b0);

    // 3: mismatching pair raises update error
    do_reset(1);
    step(1'b1, 8'h3C, 1'b0, 8'h00);
    step(1'b1, 8'h3D, 1'b0, 8'h00); idle(); @(negedge clk);
    check("t3_update_err", bus.update_err_o, 1'b1);
    check("t3_q", bus.q_o, 8'h5A);
    check("t3_qe", bus.qe_o, 1'b0);
    idle(); @(negedge clk);
    check("t3_update_err_pulse", bus.update_err_o, 1'b0);

    // 4: phase clear discards a simultaneous write
    do_reset(1);
    step(1'b1, 8'h3C, 1'b0, 8'h00);
    step(1'b1, 8'h3C, 1'b1, 8'h00); idle(); @(negedge clk);
    check("t4_staged_cleared", bus.staged_o, 1'b0);
    step(1'b1, 8'h3C, 1'b0, 8'h00); idle(); @(negedge clk);
    check("t4_staged", bus.staged_o, 1'b1);
    check("t4_q", bus.q_o, 8'h5A);

    // 5: injected shadow fault, sticky storage error survives a commit
    do_reset(1);
    step(1'b0, 8'h00, 1'b0, 8'h01); idle(); @(negedge clk);
    check("t5_err_not_yet", bus.storage_err_o, 1'b0);
    idle(); @(negedge clk);
    check("t5_storage_err", bus.storage_err_o, 1'b1);
    step(1'b1, 8'hA5, 1'b0, 8'h00);
    step(1'b1, 8'hA5, 1'b0, 8'h00); idle(); @(negedge clk);
    check("t5_q", bus.q_o, 8'hA5);
    check("t5_storage_err_sticky", bus.storage_err_o, 1'b1);

    // 6: reset in the middle of a staged pair
    do_reset(1);
    step(1'b1, 8'h3C, 1'b0, 8'h00);
    do_reset(1);
    step(1'b1, 8'h3C, 1'b0, 8'h00); idle(); @(negedge clk);
    check("t6_staged", bus.staged_o, 1'b1);
    check("t6_q", bus.q_o, 8'h5A);

    // Randomized traffic, biased toward completing pairs
    do_reset(1);
    for (int i = 0; i < 600; i++) begin
      bit         we, clr;
      logic [7:0] wd, inj;
      if ($urandom_range(0, 149) == 0) do_reset($urandom_range(1, 3));
      we  = ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 9) == 0);
      wd  = 8'($urandom);
      if (m_pend && $urandom_range(0, 2) != 0) wd = m_stage;
      inj = ($urandom_range(0, 39) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      step(we, wd, clr, inj);
    end
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
